csa_seq_ctrl: RTL

//   Sequencer that adds two WIDTH-bit operands using one shared 4-bit csa slice, one nibble per clock.
//   The carry is chained through a register, LSB nibble first.

---
 rtl/csa_seq_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/csa_seq_ctrl.sv
// Multi-cycle WIDTH-bit adder: one shared 4-bit carry-select slice is applied
// once per clock, LSB nibble first, with the carry chained through a register.

module csa (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [2:0] w_lo;
  logic [2:0] w_hi0;
  logic [2:0] w_hi1;

  // Upper half is precomputed for both carry values and selected by the lower carry
  assign w_lo  = 3'(a[1:0]) + 3'(b[1:0]) + 3'(cin);
  assign w_hi0 = 3'(a[3:2]) + 3'(b[3:2]);
  assign w_hi1 = w_hi0 + 3'd1;

  assign sum  = {(w_lo[2] ? w_hi1[1:0] : w_hi0[1:0]), w_lo[1:0]};
  assign cout = w_lo[2] ? w_hi1[2] : w_hi0[2];

endmodule

module csa_seq_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / 4;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("csa_seq_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IDXW-1:0] r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic            r_carry;
  logic            r_cout;

  logic            w_accept;
  logic            w_last;
  logic [WIDTH-1:0] w_a_sh;
  logic [WIDTH-1:0] w_b_sh;
  logic [3:0]      w_csa_a;
  logic [3:0]      w_csa_b;
  logic            w_csa_cin;
  logic [3:0]      w_csa_sum;
  logic            w_csa_cout;

  assign start_ready = (r_state == S_IDLE) & ~rst;
  assign res_valid   = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign res_sum     = r_sum;
  assign res_cout    = r_cout;

  assign w_accept = start_valid & start_ready;
  assign w_last   = (r_idx == LAST_IDX);

  // Slice operands are forced to zero outside RUN
  assign w_a_sh    = r_a >> {r_idx, 2'b00};
  assign w_b_sh    = r_b >> {r_idx, 2'b00};
  assign w_csa_a   = (r_state == S_RUN) ? w_a_sh[3:0] : 4'd0;
  assign w_csa_b   = (r_state == S_RUN) ? w_b_sh[3:0] : 4'd0;
  assign w_csa_cin = (r_state == S_RUN) ? r_carry : 1'b0;

  csa u_csa (
    .a    (w_csa_a),
    .b    (w_csa_b),
    .cin  (w_csa_cin),
    .sum  (w_csa_sum),
    .cout (w_csa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  if (res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_carry <= op_cin;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_sum[{r_idx, 2'b00} +: 4] <= w_csa_sum;
          r_carry                    <= w_csa_cout;
          if (w_last) begin
            r_cout <= w_csa_cout;
            r_idx  <= '0;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
